// File: rtl/execute_stage.sv
// MIPS EX stage: ALU, branch resolution and the EX/MEM bundle register (1-cycle latency).
// Define EXECUTE_MULDIV_EN for iterative MULTU/DIVU with HI/LO; the stage stalls upstream while busy.
module execute_stage #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 5,
  parameter int IMM_WIDTH = 16,
  parameter int PCWIDTH   = 32
) (
  input  logic                 es_clk,
  input  logic                 es_rst,
  input  logic                 es_i_ce,
  input  logic [5:0]           es_i_opcode,
  input  logic [5:0]           es_i_funct,
  input  logic [DWIDTH-1:0]    es_i_data_rs,
  input  logic [DWIDTH-1:0]    es_i_data_rt,
  input  logic [IMM_WIDTH-1:0] es_i_imm,
  input  logic [PCWIDTH-1:0]   es_i_pc,
  input  logic [AWIDTH-1:0]    es_i_rd_addr,
  input  logic                 es_i_alu_src,
  input  logic                 es_i_reg_wr,
  input  logic                 es_i_memread,
  input  logic                 es_i_memwrite,
  input  logic                 es_i_memtoreg,
  input  logic                 es_i_branch,
  output logic                 es_o_ce,
  output logic [DWIDTH-1:0]    es_o_alu_result,
  output logic [DWIDTH-1:0]    es_o_data_rt,
  output logic [AWIDTH-1:0]    es_o_rd_addr,
  output logic                 es_o_reg_wr,
  output logic                 es_o_memread,
  output logic                 es_o_memwrite,
  output logic                 es_o_memtoreg,
  output logic                 es_o_branch_taken,
  output logic [PCWIDTH-1:0]   es_o_branch_target,
  output logic                 es_o_stall
);
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000, OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111, OP_LW   = 6'b100011, OP_SW   = 6'b101011;
  localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010, F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010, F_SLTU = 6'b101011;

  logic [DWIDTH-1:0]  w_sext, w_zext, w_opb, w_result;
  logic [PCWIDTH-1:0] w_boff, w_target;
  logic [4:0]         w_shamt;
  logic               w_known, w_taken, w_take, w_stall;

`ifdef EXECUTE_MULDIV_EN
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001, F_DIVU = 6'b011011;
  localparam int CW = $clog2(DWIDTH);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t            r_state, w_state_nxt;
  logic [DWIDTH-1:0] r_hi, r_lo, r_wh, r_wl, r_opb;
  logic [CW-1:0]     r_cnt;
  logic              r_is_div, w_md_start;
  logic [DWIDTH:0]   w_mul_sum, w_rem_sh, w_diff;
`endif

  assign w_sext  = {{(DWIDTH-IMM_WIDTH){es_i_imm[IMM_WIDTH-1]}}, es_i_imm};
  assign w_zext  = {{(DWIDTH-IMM_WIDTH){1'b0}}, es_i_imm};
  assign w_shamt = es_i_imm[10:6];
  assign w_opb   = !es_i_alu_src ? es_i_data_rt :
                   (es_i_opcode == OP_ANDI || es_i_opcode == OP_ORI || es_i_opcode == OP_XORI) ? w_zext : w_sext;

  always_comb begin
    w_result = '0;
    w_known  = 1'b1;
    case (es_i_opcode)
      OP_RTYPE: begin
        case (es_i_funct)
          F_ADD, F_ADDU: w_result = es_i_data_rs + w_opb;
          F_SUB, F_SUBU: w_result = es_i_data_rs - w_opb;
          F_AND:  w_result = es_i_data_rs & w_opb;
          F_OR:   w_result = es_i_data_rs | w_opb;
          F_XOR:  w_result = es_i_data_rs ^ w_opb;
          F_NOR:  w_result = ~(es_i_data_rs | w_opb);
          F_SLT:  w_result = {{(DWIDTH-1){1'b0}}, $signed(es_i_data_rs) < $signed(w_opb)};
          F_SLTU: w_result = {{(DWIDTH-1){1'b0}}, es_i_data_rs < w_opb};
          F_SLL:  w_result = es_i_data_rt << w_shamt;
          F_SRL:  w_result = es_i_data_rt >> w_shamt;
          F_SRA:  w_result = $signed(es_i_data_rt) >>> w_shamt;
`ifdef EXECUTE_MULDIV_EN
          F_MFHI: w_result = r_hi;
          F_MFLO: w_result = r_lo;
`endif
          default: w_known = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: w_result = es_i_data_rs + w_opb;
      OP_SLTI: w_result = {{(DWIDTH-1){1'b0}}, $signed(es_i_data_rs) < $signed(w_opb)};
      OP_ANDI: w_result = es_i_data_rs & w_opb;
      OP_ORI:  w_result = es_i_data_rs | w_opb;
      OP_XORI: w_result = es_i_data_rs ^ w_opb;
      OP_LUI:  w_result = {es_i_imm, {(DWIDTH-IMM_WIDTH){1'b0}}};
      OP_LW, OP_SW: w_result = es_i_data_rs + w_sext;
      OP_BEQ, OP_BNE: w_result = '0;
      default: w_known = 1'b0;
    endcase
  end

  assign w_boff   = {{(PCWIDTH-IMM_WIDTH){es_i_imm[IMM_WIDTH-1]}}, es_i_imm};
  assign w_target = es_i_pc + PCWIDTH'(4) + (w_boff << 2);
  assign w_taken  = es_i_branch && ((es_i_opcode == OP_BEQ && es_i_data_rs == es_i_data_rt) ||
                                    (es_i_opcode == OP_BNE && es_i_data_rs != es_i_data_rt));
  assign w_take   = es_i_ce && !w_stall;

`ifdef EXECUTE_MULDIV_EN
  assign w_md_start = es_i_ce && es_i_opcode == OP_RTYPE && (es_i_funct == F_MULTU || es_i_funct == F_DIVU);

  always_ff @(posedge es_clk) begin
    if (!es_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_md_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == CW'(DWIDTH-1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_stall = es_rst && ((r_state == S_IDLE && w_md_start) || r_state == S_BUSY);
  end

  // Multiply: {r_wh,r_wl} is the shift-add product register. Divide: r_wh remainder, r_wl quotient.
  assign w_mul_sum = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_opb} : '0);
  assign w_rem_sh  = {r_wh, r_wl[DWIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_opb};

  always_ff @(posedge es_clk) begin
    if (!es_rst) begin
      r_hi <= '0; r_lo <= '0; r_wh <= '0; r_wl <= '0; r_opb <= '0;
      r_cnt <= '0; r_is_div <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_md_start) begin
          r_wh <= '0; r_wl <= es_i_data_rs; r_opb <= es_i_data_rt;
          r_is_div <= (es_i_funct == F_DIVU); r_cnt <= '0;
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (!r_is_div) begin
            r_wh <= w_mul_sum[DWIDTH:1];
            r_wl <= {w_mul_sum[0], r_wl[DWIDTH-1:1]};
          end else if (!w_diff[DWIDTH]) begin
            r_wh <= w_diff[DWIDTH-1:0];
            r_wl <= {r_wl[DWIDTH-2:0], 1'b1};
          end else begin
            r_wh <= w_rem_sh[DWIDTH-1:0];
            r_wl <= {r_wl[DWIDTH-2:0], 1'b0};
          end
        end
        S_DONE: begin r_hi <= r_wh; r_lo <= r_wl; end
        default: ;
      endcase
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  assign es_o_stall = w_stall;

  always_ff @(posedge es_clk) begin
    if (!es_rst) begin
      es_o_ce <= 1'b0; es_o_alu_result <= '0; es_o_data_rt <= '0; es_o_rd_addr <= '0;
      es_o_reg_wr <= 1'b0; es_o_memread <= 1'b0; es_o_memwrite <= 1'b0; es_o_memtoreg <= 1'b0;
      es_o_branch_taken <= 1'b0; es_o_branch_target <= '0;
    end else begin
      es_o_ce            <= w_take;
      es_o_alu_result    <= w_result;
      es_o_data_rt       <= es_i_data_rt;
      es_o_rd_addr       <= es_i_rd_addr;
      es_o_reg_wr        <= w_take && es_i_reg_wr && w_known;
      es_o_memread       <= w_take && es_i_memread;
      es_o_memwrite      <= w_take && es_i_memwrite;
      es_o_memtoreg      <= w_take && es_i_memtoreg;
      es_o_branch_taken  <= w_take && w_taken;
      es_o_branch_target <= w_target;
    end
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline. Sits directly downstream of decoder_stage and consumes its decoded bundle: opcode, funct, rs/rt data, 16-bit imm and control bits.
- Performs ALU operations and resolves branches, then registers the result plus pass-through controls into the EX/MEM bundle for the memory stage.
- Raises a stall for the optional multi-cycle multiply/divide unit.

Parameters:
- DWIDTH, 32, datapath width
- AWIDTH, 5, register-address width
- IMM_WIDTH, 16, immediate width
- PCWIDTH, 32, program-counter width

Ports:
- es_clk  in  1  clock, rising edge
- es_rst  in  1  reset, synchronous, active-low
- es_i_ce  in  1  input bundle valid
- es_i_opcode  in  6  opcode
- es_i_funct  in  6  funct field
- es_i_data_rs  in  DWIDTH  rs operand
- es_i_data_rt  in  DWIDTH  rt operand
- es_i_imm  in  IMM_WIDTH  immediate; shamt = imm[10:6]
- es_i_pc  in  PCWIDTH  PC of this instruction
- es_i_rd_addr  in  AWIDTH  destination register, already muxed by reg_dst
- es_i_alu_src  in  1  1 = immediate operand B
- es_i_reg_wr / es_i_memread / es_i_memwrite / es_i_memtoreg / es_i_branch  in  1 each  controls
- es_o_ce  out  1  output bundle valid
- es_o_alu_result  out  DWIDTH  ALU result or memory address
- es_o_data_rt  out  DWIDTH  store data
- es_o_rd_addr  out  AWIDTH  destination register
- es_o_reg_wr / es_o_memread / es_o_memwrite / es_o_memtoreg  out  1 each  registered pass-through controls
- es_o_branch_taken  out  1  branch resolved taken
- es_o_branch_target  out  PCWIDTH  branch target
- es_o_stall  out  1  upstream must hold its bundle

Behaviour:
- One clock, es_clk. Reset es_rst is synchronous, active-low. While es_rst=0, at each rising edge all registered outputs clear to 0 and the FSM goes to IDLE.
- es_o_stall is combinational and is 0 whenever es_rst=0.
- Latency is 1 cycle: the bundle presented with es_i_ce=1 and es_o_stall=0 appears on the outputs after the next edge.
- When es_i_ce=0, es_o_ce=0 and all controls register 0, producing a bubble.
- Operand B = es_i_alu_src ? ext(imm) : es_i_data_rt.
  - ext is zero-extension for ANDI/ORI/XORI and sign-extension otherwise.
- R-type (opcode 000000), by funct:
  - ADD 100000 and ADDU 100001: sum
  - SUB 100010 and SUBU 100011: difference
  - AND 100100, OR 100101, XOR 100110, NOR 100111
  - SLT 101010: signed compare; SLTU 101011: unsigned compare
  - SLL 000000, SRL 000010, SRA 000011: shift rt by shamt
- I-type, by opcode:
  - ADDI 001000, ADDIU 001001
  - SLTI 001010: signed compare
  - ANDI 001100, ORI 001101, XORI 001110
  - LUI 001111: {imm, 16'b0}
  - LW 100011 and SW 101011: result = rs + sext(imm)
- Arithmetic wraps modulo 2^DWIDTH. No overflow trap.
- Unknown opcode or funct: result 0 and es_o_reg_wr forced to 0. Other controls pass through.
- Branches:
  - BEQ 000100 is taken when rs==rt; BNE 000101 is taken when rs!=rt. Taken also requires es_i_branch=1.
  - es_o_branch_target = pc + 4 + (sext(imm) << 2), registered.
  - es_o_branch_taken is 1 for exactly one cycle per taken branch.
  - Flushing younger instructions is the hazard unit's job, not this block's.
- es_o_data_rt always registers es_i_data_rt.

Optional Feature:
- Macro: EXECUTE_MULDIV_EN.
- Enabled, adds HI/LO registers (reset 0) and ops: MULTU 011001, DIVU 011011, MFHI 010000, MFLO 010010.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - A valid MULTU/DIVU at the input drives es_o_stall=1.
  - At the next edge the FSM goes to BUSY and the count is cleared.
- BUSY:
  - es_o_stall=1 and es_o_ce=0.
  - One shift-add (MULTU) or restoring-division (DIVU) iteration per cycle.
  - After 32 iterations: go to DONE.
- DONE:
  - es_o_stall=0. HI/LO are written at this edge.
  - The held instruction retires with es_o_ce=1 and es_o_reg_wr=0; the FSM returns to IDLE.
  - A MULTU occupies EX for 34 cycles in total.
- DIVU by 0 gives LO=all-ones and HI=dividend, with the same timing.
- MFHI and MFLO read HI/LO in 1 cycle with es_o_reg_wr passed through.
- es_rst=0 during BUSY aborts the operation: FSM to IDLE, HI/LO=0.
- Disabled: no FSM, no HI/LO. These four functs are treated as unknown and es_o_stall is tied to 0.

Test Plan:
- ADD: rs=5, rt=7, es_i_reg_wr=1, rd=1 -> next cycle alu_result=12, rd_addr=1, reg_wr=1, ce=1.
- SLTI: rs=0xFFFFFFFF, imm=10, alu_src=1 -> alu_result=1. Repeat with SLTU and rt=10 -> result 0.
- LW: rs=0x100, imm=0xFFFC -> alu_result=0xFC, memread=1, memtoreg=1.
- BEQ: rs=rt=3, branch=1, pc=0x40, imm=0x0002 -> branch_taken=1 for one cycle, target=0x4C. BNE with the same operands -> taken=0.
- Reset mid-stream: apply es_rst=0 with ce=1 -> after the edge every output is 0. es_i_ce=0 -> bubble with all controls 0.
- MULDIV (macro defined): MULTU 0x10000 x 0x10000 -> stall high 33 cycles, then HI=1, LO=0. MFLO -> result 0. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
